// File: rtl/serial_loop_monitor_pkg.sv
// Shared types and helpers for the multi-channel serial loop monitor.
package serial_mon_pkg;

    // TX drive mode, common to all channels.
    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_SYNC  = 2'd1,
        MODE_MUTE  = 2'd2,
        MODE_BREAK = 2'd3
    } mode_e;

    // Activity LED pulse-stretcher states.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } stretch_state_e;

    // 50 ms LED on-time at a 48 MHz ref_clk.
    localparam int unsigned DEFAULT_STRETCH_CYCLES = 2400000;

    // Bits needed to hold values 0..value-1; never less than 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        bits = 1;
        for (int i = 1; i < 32; i++) begin
            if (((value - 1) >> i) != 0) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/serial_loop_monitor_if.sv
// Pin-side bundle of the serial loop monitor: RX in, controls, TX/LED/OD/count out.
interface serial_loop_monitor_if #(
    parameter int CHANNELS = 1,
    parameter int CNT_W    = 8
);
    logic [CHANNELS-1:0]       rx_in;
    logic [1:0]                mode;
    logic                      cnt_clr;
    logic [CHANNELS-1:0]       tx_out;
    logic [CHANNELS-1:0]       led_n;
    logic [CHANNELS-1:0]       od_oe;
    logic [CHANNELS*CNT_W-1:0] act_cnt;

    // Board / top-level side: drives the pins and controls.
    modport master (
        output rx_in, mode, cnt_clr,
        input  tx_out, led_n, od_oe, act_cnt
    );

    // Monitor side.
    modport slave (
        input  rx_in, mode, cnt_clr,
        output tx_out, led_n, od_oe, act_cnt
    );
endinterface

// File: rtl/serial_loop_monitor_act_channel.sv
// One serial line: synchroniser, falling-edge detect, LED stretcher FSM,
// open-drain mirror register and saturating edge counter.
module act_channel
    import serial_mon_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = DEFAULT_STRETCH_CYCLES,
    parameter int CNT_W          = 8
) (
    input  logic             ref_clk,
    input  logic             rst_n,
    input  logic             rx_in,
    input  logic             cnt_clr,
    output logic             rx_s,
    output logic             led_n,
    output logic             od_oe,
    output logic [CNT_W-1:0] act_cnt
);
    localparam int               STR_W      = clog2(STRETCH_CYCLES);
    localparam logic [STR_W-1:0] STR_RELOAD = STR_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_prev_q;
    logic                   fe;
    stretch_state_e         state_q, state_d;
    logic [STR_W-1:0]       str_cnt_q, str_cnt_d;
    logic                   led_on_d;

    // Synchroniser chain, reset to the idle-high line level.
    // NOTE: every clocked process uses non-blocking (<=) so all flops sample pre-edge values.
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // One-cycle history of the synchronised line for edge detection.
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev_q <= 1'b1;
        end else begin
            rx_prev_q <= rx_s;
        end
    end

    assign fe = rx_prev_q & ~rx_s;

    // Stretcher state register.
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            str_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            str_cnt_q <= str_cnt_d;
        end
    end

    // Stretcher next state: load on an edge, count down, drop to IDLE at zero.
    // NOTE: defaults at the top of a combinational block keep every path assigned, so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        str_cnt_d = str_cnt_q;
        if (fe) begin
            state_d   = ST_ACTIVE;
            str_cnt_d = STR_RELOAD;
        end else if (state_q == ST_ACTIVE) begin
            if (str_cnt_q != '0) begin
                str_cnt_d = str_cnt_q - STR_W'(1);
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // LED is lit while stretching or while the line is held low.
    always_comb begin
        led_on_d = (state_d == ST_ACTIVE) | ~rx_s;
    end

    // Registered LED and open-drain mirror drives.
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            led_n <= 1'b1;
            od_oe <= 1'b0;
        end else begin
            led_n <= ~led_on_d;
            od_oe <= ~rx_s;
        end
    end

    // Saturating falling-edge counter; clear wins over a coincident edge.
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            act_cnt <= '0;
        end else if (cnt_clr) begin
            act_cnt <= '0;
        end else if (fe && (act_cnt != CNT_MAX)) begin
            act_cnt <= act_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_loop_monitor.sv
// Multi-channel RX->TX loopback monitor: per-channel activity blocks plus
// the shared TX mode mux and output bus packing.
module serial_loop_monitor
    import serial_mon_pkg::*;
#(
    parameter int CHANNELS       = 1,
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = DEFAULT_STRETCH_CYCLES,
    parameter int CNT_W          = 8
) (
    input  logic                 ref_clk,
    input  logic                 rst_n,
    serial_loop_monitor_if.slave bus
);
    mode_e               mode;
    logic [CHANNELS-1:0] rx_s;
    logic [CHANNELS-1:0] tx_d, tx_q;

    assign mode = mode_e'(bus.mode);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        act_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .STRETCH_CYCLES (STRETCH_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .ref_clk (ref_clk),
            .rst_n   (rst_n),
            .rx_in   (bus.rx_in[i]),
            .cnt_clr (bus.cnt_clr),
            .rx_s    (rx_s[i]),
            .led_n   (bus.led_n[i]),
            .od_oe   (bus.od_oe[i]),
            .act_cnt (bus.act_cnt[i*CNT_W +: CNT_W])
        );
    end

    // Registered TX level for the non-PASS modes; PASS keeps it tracking rx_s
    // so a switch to SYNC is seamless.
    always_comb begin
        tx_d = rx_s;
        unique case (mode)
            MODE_MUTE:  tx_d = '1;
            MODE_BREAK: tx_d = '0;
            default:    tx_d = rx_s;
        endcase
    end

    // TX register, idle high in reset.
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q <= '1;
        end else begin
            tx_q <= tx_d;
        end
    end

    // PASS is a combinational wire from the RX pins, live even during reset.
    assign bus.tx_out = (mode == MODE_PASS) ? bus.rx_in : tx_q;

endmodule

// File: tb/tb_serial_loop_monitor.sv
// Scoreboard bench for serial_loop_monitor (2 channels, stretch 10, 2-stage sync).
module tb_serial_loop_monitor;
    import serial_mon_pkg::*;

    localparam int CH = 2;
    localparam int CW = 8;
    localparam int SS = 2;
    localparam int SC = 10;

    typedef enum int {K_TX, K_LED, K_OD, K_CNT0, K_CNT1} kind_e;
    typedef struct {
        int         at;     // cycle to check; -1 = check immediately
        kind_e      kind;
        logic [7:0] exp;
        string      name;
    } exp_t;

    logic ref_clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    event chk_now;

    always #10 ref_clk = ~ref_clk;
    always @(posedge ref_clk) cyc <= cyc + 1;

    serial_loop_monitor_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

    serial_loop_monitor #(
        .CHANNELS       (CH),
        .SYNC_STAGES    (SS),
        .STRETCH_CYCLES (SC),
        .CNT_W          (CW)
    ) dut (
        .ref_clk (ref_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    function automatic logic [7:0] observe(input kind_e k);
        logic [7:0] v;
        v = '0;
        case (k)
            K_TX:    v = {6'd0, bus.tx_out};
            K_LED:   v = {6'd0, bus.led_n};
            K_OD:    v = {6'd0, bus.od_oe};
            K_CNT0:  v = bus.act_cnt[7:0];
            K_CNT1:  v = bus.act_cnt[15:8];
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic check(input int idx);
        logic [7:0] act;
        act = observe(sb[idx].kind);
        vectors++;
        if (act !== sb[idx].exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h",
                     sb[idx].name, cyc, act, sb[idx].exp);
        end
    endtask

    task automatic evaluate(input bit imm);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (imm ? (sb[i].at < 0) : (sb[i].at == cyc)) begin
                check(i);
                sb.delete(i);
            end else if (!imm && sb[i].at >= 0 && sb[i].at < cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL %s: expectation for cycle %0d was never checked", sb[i].name, sb[i].at);
                sb.delete(i);
            end
        end
    endtask

    // Monitor: compares due expectations away from the active edge.
    initial forever begin
        @(negedge ref_clk);
        evaluate(1'b0);
    end

    // Monitor: immediate comparisons for asynchronous events.
    initial forever begin
        @(chk_now);
        evaluate(1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge ref_clk);
        #1;
    endtask

    task automatic expect_at(input int dly, input kind_e k, input logic [7:0] e, input string nm);
        sb.push_back('{cyc + dly, k, e, nm});
    endtask

    task automatic expect_now(input kind_e k, input logic [7:0] e, input string nm);
        sb.push_back('{-1, k, e, nm});
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.rx_in   = 2'b00;
        bus.mode    = MODE_SYNC;
        bus.cnt_clr = 1'b0;
        tick(3);

        // 1. Reset values, then release with both lines low.
        expect_at(0, K_TX,   8'h3, "rst_tx");
        expect_at(0, K_LED,  8'h3, "rst_led");
        expect_at(0, K_OD,   8'h0, "rst_od");
        expect_at(0, K_CNT0, 8'd0, "rst_cnt0");
        expect_at(0, K_CNT1, 8'd0, "rst_cnt1");
        tick(1);
        rst_n = 1'b1;
        expect_at(2, K_OD,   8'h0, "od_before_sync");
        expect_at(3, K_OD,   8'h3, "od_after_release");
        expect_at(3, K_CNT0, 8'd1, "release_edge_cnt");
        tick(3);
        bus.rx_in = 2'b11;
        tick(16);
        expect_at(0, K_LED, 8'h3, "led_settled");
        bus.cnt_clr = 1'b1;
        tick(1);
        bus.cnt_clr = 1'b0;
        expect_at(0, K_CNT0, 8'd0, "clr_cnt0");
        expect_at(0, K_CNT1, 8'd0, "clr_cnt1");
        tick(2);

        // 2. TX latency and mode switching.
        bus.rx_in = 2'b10;
        expect_at(2, K_TX, 8'h3, "sync_lat2");
        expect_at(3, K_TX, 8'h2, "sync_lat3");
        tick(4);
        bus.mode  = MODE_PASS;
        bus.rx_in = 2'b11;
        expect_at(0, K_TX, 8'h3, "pass_hi");
        tick(1);
        bus.rx_in = 2'b10;
        expect_at(0, K_TX, 8'h2, "pass_lo");
        tick(1);
        bus.mode  = MODE_MUTE;
        bus.rx_in = 2'b11;
        expect_at(1, K_TX, 8'h3, "mute");
        tick(2);
        bus.mode = MODE_BREAK;
        expect_at(1, K_TX, 8'h0, "break");
        tick(2);
        bus.mode = MODE_SYNC;
        expect_at(1, K_TX, 8'h3, "sync_back");
        tick(20);

        // 3. Isolated pulse on ch1 stretches its LED only.
        bus.rx_in = 2'b01;
        expect_at(2,  K_LED,  8'h3, "stretch_before");
        expect_at(3,  K_LED,  8'h1, "stretch_on");
        expect_at(3,  K_OD,   8'h2, "od_ch1");
        expect_at(3,  K_CNT1, 8'd1, "cnt1_one");
        expect_at(12, K_LED,  8'h1, "stretch_last");
        expect_at(13, K_LED,  8'h3, "stretch_off");
        tick(3);
        bus.rx_in = 2'b11;
        tick(20);

        // 4. Retrigger on ch0: edges 6 cycles apart.
        bus.rx_in = 2'b10;
        expect_at(3,  K_LED, 8'h2, "retrig_on");
        expect_at(8,  K_LED, 8'h2, "retrig_gap");
        expect_at(12, K_LED, 8'h2, "retrig_extend");
        expect_at(18, K_LED, 8'h2, "retrig_last");
        expect_at(19, K_LED, 8'h3, "retrig_off");
        tick(3);
        bus.rx_in = 2'b11;
        tick(3);
        bus.rx_in = 2'b10;
        tick(3);
        bus.rx_in = 2'b11;
        tick(20);

        // 5. Saturation and clear-vs-edge priority.
        bus.cnt_clr = 1'b1;
        tick(1);
        bus.cnt_clr = 1'b0;
        expect_at(0, K_CNT0, 8'd0, "sat_start");
        for (int i = 0; i < 10; i++) begin
            bus.rx_in = 2'b10;
            tick(2);
            bus.rx_in = 2'b11;
            tick(2);
        end
        expect_at(0, K_CNT0, 8'd10, "cnt_ten");
        for (int i = 0; i < 290; i++) begin
            bus.rx_in = 2'b10;
            tick(2);
            bus.rx_in = 2'b11;
            tick(2);
        end
        expect_at(0, K_CNT0, 8'd255, "cnt_saturated");
        expect_at(0, K_CNT1, 8'd0,   "cnt1_untouched");
        bus.rx_in = 2'b10;
        tick(2);
        bus.cnt_clr = 1'b1;
        tick(1);
        bus.cnt_clr = 1'b0;
        expect_at(0, K_CNT0, 8'd0, "clr_beats_edge");
        bus.rx_in = 2'b11;
        tick(4);
        bus.rx_in = 2'b10;
        expect_at(2, K_CNT0, 8'd0, "clr_edge_not_counted");
        expect_at(3, K_CNT0, 8'd1, "next_edge_counts");
        tick(3);
        bus.rx_in = 2'b11;
        tick(20);

        // 6. Asynchronous reset in the middle of a ch1 stretch.
        bus.rx_in = 2'b01;
        expect_at(7, K_LED,  8'h1, "pre_rst_led");
        expect_at(7, K_OD,   8'h2, "pre_rst_od");
        expect_at(7, K_CNT1, 8'd1, "pre_rst_cnt1");
        tick(8);
        rst_n = 1'b0;
        #1;
        expect_now(K_LED,  8'h3, "async_led");
        expect_now(K_OD,   8'h0, "async_od");
        expect_now(K_CNT0, 8'd0, "async_cnt0");
        expect_now(K_CNT1, 8'd0, "async_cnt1");
        expect_now(K_TX,   8'h3, "async_tx_sync");
        -> chk_now;
        #1;
        bus.mode  = MODE_PASS;
        bus.rx_in = 2'b10;
        #1;
        expect_now(K_TX, 8'h2, "rst_pass_follows");
        -> chk_now;
        #1;
        bus.mode = MODE_BREAK;
        #1;
        expect_now(K_TX, 8'h3, "rst_break_idle");
        -> chk_now;
        #1;
        bus.mode  = MODE_SYNC;
        bus.rx_in = 2'b11;
        tick(2);
        rst_n = 1'b1;
        expect_at(1,  K_LED,  8'h3, "post_rst_led1");
        expect_at(3,  K_LED,  8'h3, "post_rst_led3");
        expect_at(5,  K_OD,   8'h0, "post_rst_od");
        expect_at(6,  K_LED,  8'h3, "post_rst_led6");
        expect_at(10, K_LED,  8'h3, "post_rst_led10");
        expect_at(14, K_LED,  8'h3, "post_rst_led14");
        expect_at(14, K_CNT1, 8'd0, "post_rst_cnt1");
        tick(16);

        // 7. Simultaneous edges on both channels.
        bus.rx_in = 2'b00;
        expect_at(3,  K_CNT0, 8'd1, "both_cnt0");
        expect_at(3,  K_CNT1, 8'd1, "both_cnt1");
        expect_at(3,  K_LED,  8'h0, "both_led_on");
        expect_at(12, K_LED,  8'h0, "both_led_last");
        expect_at(13, K_LED,  8'h3, "both_led_off");
        tick(3);
        bus.rx_in = 2'b11;
        tick(16);

        tick(2);
        foreach (sb[i]) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: expectation for cycle %0d left unchecked", sb[i].name, sb[i].at);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
